// File: rtl/minn_antenna_path.sv
// Per-antenna Minn front end: running lag-Q autocorrelation and energy window sums
// with their quarter-window-delayed copies and a fully-populated indicator.
module minn_antenna_path #(
    parameter int INPUT_WIDTH  = 12,
    parameter int QUARTER_LEN  = 512,
    parameter int SUM_GROWTH   = (QUARTER_LEN <= 1) ? 1 : $clog2(QUARTER_LEN + 1),
    parameter int CORR_WIDTH   = 2 * INPUT_WIDTH + 1 + SUM_GROWTH,
    parameter int ENERGY_WIDTH = 2 * INPUT_WIDTH + 1 + SUM_GROWTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  in_i,
    input  logic signed [INPUT_WIDTH-1:0]  in_q,
    output logic signed [CORR_WIDTH-1:0]   corr_recent,
    output logic signed [CORR_WIDTH-1:0]   corr_previous,
    output logic signed [ENERGY_WIDTH-1:0] energy_recent,
    output logic signed [ENERGY_WIDTH-1:0] energy_previous,
    output logic signed [ENERGY_WIDTH-1:0] energy_previous2,
    output logic                           taps_valid
);

    localparam int PW    = 2 * INPUT_WIDTH + 1;
    localparam int PTR_W = (QUARTER_LEN > 1) ? $clog2(QUARTER_LEN) : 1;
    localparam int CNT_W = $clog2(4 * QUARTER_LEN + 1);

    logic signed [INPUT_WIDTH-1:0]  si_mem [QUARTER_LEN];
    logic signed [INPUT_WIDTH-1:0]  sq_mem [QUARTER_LEN];
    logic signed [PW-1:0]           p_mem  [QUARTER_LEN];
    logic signed [PW-1:0]           e_mem  [QUARTER_LEN];
    // Two chained depth-Q stages give both the Q and 2Q delays off a single pointer.
    logic signed [CORR_WIDTH-1:0]   c1_mem [QUARTER_LEN];
    logic signed [CORR_WIDTH-1:0]   c2_mem [QUARTER_LEN];
    logic signed [ENERGY_WIDTH-1:0] e1_mem [QUARTER_LEN];
    logic signed [ENERGY_WIDTH-1:0] e2_mem [QUARTER_LEN];

    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           taps_q, taps_d;
    logic signed [CORR_WIDTH-1:0]   c_q, c_d, cprev_q;
    logic signed [ENERGY_WIDTH-1:0] e_q, e_d, eprev_q, eprev2_q;

    logic signed [2*INPUT_WIDTH-1:0] prod_ii, prod_qq, sqr_i, sqr_q;
    logic signed [PW-1:0]            p_new, pw_new;

    always_comb begin
        prod_ii = in_i * si_mem[ptr_q];
        prod_qq = in_q * sq_mem[ptr_q];
        sqr_i   = in_i * in_i;
        sqr_q   = in_q * in_q;
        p_new   = PW'(prod_ii) + PW'(prod_qq);
        pw_new  = PW'(sqr_i) + PW'(sqr_q);
        c_d     = c_q + CORR_WIDTH'(p_new) - CORR_WIDTH'(p_mem[ptr_q]);
        e_d     = e_q + ENERGY_WIDTH'(pw_new) - ENERGY_WIDTH'(e_mem[ptr_q]);
        ptr_d   = (ptr_q == PTR_W'(QUARTER_LEN - 1)) ? '0 : ptr_q + 1'b1;
        cnt_d   = (cnt_q == CNT_W'(4 * QUARTER_LEN)) ? cnt_q : cnt_q + 1'b1;
        taps_d  = taps_q | (cnt_q == CNT_W'(4 * QUARTER_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            cnt_q    <= '0;
            taps_q   <= 1'b0;
            c_q      <= '0;
            e_q      <= '0;
            cprev_q  <= '0;
            eprev_q  <= '0;
            eprev2_q <= '0;
            for (int unsigned k = 0; k < QUARTER_LEN; k++) begin
                si_mem[k] <= '0;
                sq_mem[k] <= '0;
                p_mem[k]  <= '0;
                e_mem[k]  <= '0;
                c1_mem[k] <= '0;
                c2_mem[k] <= '0;
                e1_mem[k] <= '0;
                e2_mem[k] <= '0;
            end
        end else if (in_valid) begin
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            taps_q        <= taps_d;
            c_q           <= c_d;
            e_q           <= e_d;
            si_mem[ptr_q] <= in_i;
            sq_mem[ptr_q] <= in_q;
            p_mem[ptr_q]  <= p_new;
            e_mem[ptr_q]  <= pw_new;
            cprev_q       <= c2_mem[ptr_q];
            c2_mem[ptr_q] <= c1_mem[ptr_q];
            c1_mem[ptr_q] <= c_d;
            eprev_q       <= e1_mem[ptr_q];
            eprev2_q      <= e2_mem[ptr_q];
            e2_mem[ptr_q] <= e1_mem[ptr_q];
            e1_mem[ptr_q] <= e_d;
        end
    end

    assign corr_recent      = c_q;
    assign corr_previous    = cprev_q;
    assign energy_recent    = e_q;
    assign energy_previous  = eprev_q;
    assign energy_previous2 = eprev2_q;
    assign taps_valid       = taps_q;

endmodule

// File: tb/tb_minn_antenna_path.sv
// Directed and randomized checks of minn_antenna_path against hand values and a direct-sum model.
module tb_minn_antenna_path;

    localparam int IW = 12;
    localparam int Q  = 4;
    localparam int CW = 2 * IW + 1 + $clog2(Q + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [IW-1:0] in_i = '0;
    logic signed [IW-1:0] in_q = '0;
    logic signed [CW-1:0] corr_recent, corr_previous;
    logic signed [CW-1:0] energy_recent, energy_previous, energy_previous2;
    logic                 taps_valid;

    int checks = 0;
    int failures = 0;

    longint hi [$];
    longint hq [$];

    minn_antenna_path #(.INPUT_WIDTH(IW), .QUARTER_LEN(Q)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .corr_recent(corr_recent), .corr_previous(corr_previous),
        .energy_recent(energy_recent), .energy_previous(energy_previous),
        .energy_previous2(energy_previous2), .taps_valid(taps_valid)
    );

    always #5 clk = ~clk;

    function automatic longint xi(int j);
        return (j < 0) ? 0 : hi[j];
    endfunction
    function automatic longint xq(int j);
        return (j < 0) ? 0 : hq[j];
    endfunction
    // Direct window sums from the sample history (no running update).
    function automatic longint mc(int m);
        longint s = 0;
        for (int k = 0; k < Q; k++)
            s += xi(m - k) * xi(m - k - Q) + xq(m - k) * xq(m - k - Q);
        return s;
    endfunction
    function automatic longint me(int m);
        longint s = 0;
        for (int k = 0; k < Q; k++)
            s += xi(m - k) * xi(m - k) + xq(m - k) * xq(m - k);
        return s;
    endfunction

    task automatic push(input logic v, input int i, input int q);
        @(negedge clk);
        in_valid = v;
        in_i = IW'(i);
        in_q = IW'(q);
        @(posedge clk);
        #1;
        if (v && !rst) begin
            hi.push_back(longint'(i));
            hq.push_back(longint'(q));
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        hi.delete();
        hq.delete();
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        int n = hi.size() - 1;
        longint ec  = mc(n);
        longint ecp = mc(n - 2 * Q);
        longint ee  = me(n);
        longint eep = me(n - Q);
        longint ee2 = me(n - 2 * Q);
        logic   et  = (hi.size() >= 4 * Q);
        checks++;
        if (longint'(corr_recent) !== ec || longint'(corr_previous) !== ecp ||
            longint'(energy_recent) !== ee || longint'(energy_previous) !== eep ||
            longint'(energy_previous2) !== ee2 || taps_valid !== et) begin
            failures++;
            $display("FAIL %s n=%0d: got c=%0d cp=%0d e=%0d ep=%0d ep2=%0d tv=%0b expected c=%0d cp=%0d e=%0d ep=%0d ep2=%0d tv=%0b",
                     name, n, longint'(corr_recent), longint'(corr_previous), longint'(energy_recent),
                     longint'(energy_previous), longint'(energy_previous2), taps_valid,
                     ec, ecp, ee, eep, ee2, et);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (corr_recent !== '0 || corr_previous !== '0 || energy_recent !== '0 ||
            energy_previous !== '0 || energy_previous2 !== '0 || taps_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: got c=%0d cp=%0d e=%0d ep=%0d ep2=%0d tv=%0b expected all 0",
                     name, corr_recent, corr_previous, energy_recent, energy_previous,
                     energy_previous2, taps_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_zero("reset_state");
    endtask

    task automatic test_constant();
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            push(1'b1, 100, 0);
            if (s == 4) begin
                check_val("const4_energy", longint'(energy_recent), 40000);
                check_val("const4_corr", longint'(corr_recent), 0);
            end
            if (s == 8) check_val("const8_corr", longint'(corr_recent), 40000);
            if (s == 15) check_val("const15_taps", longint'(taps_valid), 0);
        end
        check_val("const16_corr_prev", longint'(corr_previous), 40000);
        check_val("const16_energy_prev", longint'(energy_previous), 40000);
        check_val("const16_energy_prev2", longint'(energy_previous2), 40000);
        check_val("const16_taps", longint'(taps_valid), 1);
    endtask

    task automatic test_preamble();
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            push(1'b1, (s <= 8) ? 100 : -100, 0);
            if (s == 12) check_val("pre12_corr", longint'(corr_recent), -40000);
        end
        check_val("pre16_corr", longint'(corr_recent), 40000);
        check_val("pre16_corr_prev", longint'(corr_previous), 40000);
    endtask

    task automatic test_fullscale();
        do_reset();
        for (int s = 1; s <= 20; s++) push(1'b1, -2048, -2048);
        check_val("fs_energy", longint'(energy_recent), 33554432);
        check_val("fs_corr", longint'(corr_recent), 33554432);
        check_val("fs_corr_prev", longint'(corr_previous), 33554432);
        check_val("fs_energy_prev2", longint'(energy_previous2), 33554432);
    endtask

    task automatic test_gaps();
        do_reset();
        for (int s = 1; s <= 16; s++) begin
            push(1'b1, 100, 0);
            push(1'b0, 7, 7);
            check_model("gap_hold");
        end
        check_val("gap_corr", longint'(corr_recent), 40000);
        check_val("gap_corr_prev", longint'(corr_previous), 40000);
        check_val("gap_energy_prev2", longint'(energy_previous2), 40000);
        check_val("gap_taps", longint'(taps_valid), 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 1; s <= 10; s++) push(1'b1, 100, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_i = IW'(55);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        hi.delete();
        hq.delete();
        check_zero("mid_reset_zero");
        for (int s = 1; s <= 16; s++) begin
            push(1'b1, 100, 0);
            check_model("mid_rerun");
        end
        check_val("mid_rerun_corr_prev", longint'(corr_previous), 40000);
    endtask

    task automatic test_random();
        int acc = 0;
        do_reset();
        while (acc < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                push(1'b0, 0, 0);
                if (acc > 0) check_model("rand_idle");
            end else begin
                push(1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
                acc++;
                check_model("rand_sample");
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_preamble();
        test_fullscale();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
